// File: rtl/ysyx22041405_lsu_if.sv
// Handshake bundle for the ysyx22041405 load/store unit: instruction in, data-memory
// request/response, and write-back out. The LSU uses the master view.
interface ysyx22041405_lsu_if #(
   parameter int unsigned WIDTH = 32
);
   localparam int unsigned STRB = WIDTH / 8;

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_alu_result;
   logic [WIDTH-1:0] in_pc_add4;
   logic [WIDTH-1:0] in_rs2;
   logic [1:0]       in_mem_op;
   logic [1:0]       in_size;
   logic             in_unsigned;
   logic             in_wb_sel;

   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_addr;
   logic             req_we;
   logic [WIDTH-1:0] req_wdata;
   logic [STRB-1:0]  req_wstrb;

   logic             rsp_valid;
   logic [WIDTH-1:0] rsp_rdata;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_rf_wdata;
   logic             out_rf_we;
   logic             out_misalign;

   modport master (
      input  in_valid, in_alu_result, in_pc_add4, in_rs2, in_mem_op, in_size, in_unsigned,
             in_wb_sel, req_ready, rsp_valid, rsp_rdata, out_ready,
      output in_ready, req_valid, req_addr, req_we, req_wdata, req_wstrb, out_valid,
             out_rf_wdata, out_rf_we, out_misalign
   );

   modport slave (
      output in_valid, in_alu_result, in_pc_add4, in_rs2, in_mem_op, in_size, in_unsigned,
             in_wb_sel, req_ready, rsp_valid, rsp_rdata, out_ready,
      input  in_ready, req_valid, req_addr, req_we, req_wdata, req_wstrb, out_valid,
             out_rf_wdata, out_rf_we, out_misalign
   );
endinterface

// File: rtl/ysyx22041405_lsu.sv
// Memory-stage load/store unit: one instruction in flight, alignment checks, byte-lane
// steering, request/response bus with wait states, extended load data to write-back.
module ysyx22041405_lsu #(
   parameter int unsigned WIDTH = 32
) (
   input logic                clk,
   input logic                rst,
   ysyx22041405_lsu_if.master bus
);
   localparam int unsigned STRB = WIDTH / 8;
   localparam int unsigned OffW = $clog2(STRB);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] addr_q, addr_d;
   logic [WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB-1:0]  wstrb_q, wstrb_d;
   logic             we_q, we_d;
   logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
   logic             rf_we_q, rf_we_d;
   logic             misalign_q, misalign_d;
   logic             unsigned_q, unsigned_d;
   logic [1:0]       size_q, size_d;
   logic [OffW-1:0]  off_q, off_d;

   logic [OffW-1:0]  in_off;
   logic             is_load, is_store, misalign;
   logic [STRB-1:0]  in_strb;
   logic [WIDTH-1:0] ld_shift, ld_keep, ld_data;
   logic             ld_sign;

   assign in_off   = bus.in_alu_result[OffW-1:0];
   assign is_load  = bus.in_mem_op == 2'b01;
   assign is_store = bus.in_mem_op == 2'b10;

   // Dword never fits a 32-bit bus, regardless of address.
   always_comb begin
      unique case (bus.in_size)
         2'b00:   misalign = 1'b0;
         2'b01:   misalign = bus.in_alu_result[0];
         2'b10:   misalign = |bus.in_alu_result[1:0];
         default: misalign = (WIDTH == 32) || (|bus.in_alu_result[2:0]);
      endcase
   end

   always_comb begin
      in_strb = '0;
      for (int i = 0; i < int'(STRB); i++) begin
         in_strb[i] = (i >= int'(in_off)) && (i < int'(in_off) + (1 << bus.in_size));
      end
   end

   // Load extraction: bits above the access size are replaced by the sign (or zero).
   always_comb begin
      ld_shift = bus.rsp_rdata >> {off_q, 3'b000};
      ld_keep  = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         ld_keep[i] = i < (8 << size_q);
      end
      unique case (size_q)
         2'b00:   ld_sign = ld_shift[7];
         2'b01:   ld_sign = ld_shift[15];
         2'b10:   ld_sign = ld_shift[31];
         default: ld_sign = ld_shift[WIDTH-1];
      endcase
      ld_data = (ld_shift & ld_keep) | ({WIDTH{ld_sign & ~unsigned_q}} & ~ld_keep);
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      we_d       = we_q;
      rf_wdata_d = rf_wdata_q;
      rf_we_d    = rf_we_q;
      misalign_d = misalign_q;
      unsigned_d = unsigned_q;
      size_d     = size_q;
      off_d      = off_q;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               size_d     = bus.in_size;
               unsigned_d = bus.in_unsigned;
               off_d      = in_off;
               addr_d     = {bus.in_alu_result[WIDTH-1:OffW], {OffW{1'b0}}};
               wdata_d    = bus.in_rs2 << {in_off, 3'b000};
               wstrb_d    = '0;
               we_d       = 1'b0;
               misalign_d = 1'b0;
               rf_we_d    = 1'b0;
               rf_wdata_d = '0;
               if ((is_load || is_store) && misalign) begin
                  misalign_d = 1'b1;
                  state_d    = StDone;
               end else if (is_load) begin
                  rf_we_d = 1'b1;
                  state_d = StReq;
               end else if (is_store) begin
                  we_d    = 1'b1;
                  wstrb_d = in_strb;
                  state_d = StReq;
               end else begin
                  rf_we_d    = 1'b1;
                  rf_wdata_d = bus.in_wb_sel ? bus.in_alu_result : bus.in_pc_add4;
                  state_d    = StDone;
               end
            end
         end
         StReq: begin
            if (bus.req_ready) state_d = StWait;
         end
         StWait: begin
            if (bus.rsp_valid) begin
               if (!we_q) rf_wdata_d = ld_data;
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         we_q       <= 1'b0;
         rf_wdata_q <= '0;
         rf_we_q    <= 1'b0;
         misalign_q <= 1'b0;
         unsigned_q <= 1'b0;
         size_q     <= 2'b00;
         off_q      <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         we_q       <= we_d;
         rf_wdata_q <= rf_wdata_d;
         rf_we_q    <= rf_we_d;
         misalign_q <= misalign_d;
         unsigned_q <= unsigned_d;
         size_q     <= size_d;
         off_q      <= off_d;
      end
   end

   assign bus.in_ready     = state_q == StIdle;
   assign bus.req_valid    = state_q == StReq;
   assign bus.req_addr     = addr_q;
   assign bus.req_we       = we_q;
   assign bus.req_wdata    = wdata_q;
   assign bus.req_wstrb    = wstrb_q;
   assign bus.out_valid    = state_q == StDone;
   assign bus.out_rf_wdata = rf_wdata_q;
   assign bus.out_rf_we    = rf_we_q;
   assign bus.out_misalign = misalign_q;
endmodule

// File: tb/tb_ysyx22041405_lsu.sv
// Randomized bench for ysyx22041405_lsu: 32- and 64-bit instances share stimulus and are
// checked against an arithmetic reference of the access rules.
module tb_ysyx22041405_lsu;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx22041405_lsu_if #(.WIDTH(32)) bus32 ();
   ysyx22041405_lsu_if #(.WIDTH(64)) bus64 ();

   ysyx22041405_lsu #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
   ysyx22041405_lsu #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

   logic        use64, in_valid, uns, wb_sel, req_ready, rsp_valid, out_ready;
   logic [1:0]  mem_op, size;
   logic [63:0] alu, pc4, rs2, rdata;

   assign bus32.in_valid      = in_valid & ~use64;
   assign bus64.in_valid      = in_valid & use64;
   assign bus32.in_alu_result = alu[31:0];
   assign bus64.in_alu_result = alu;
   assign bus32.in_pc_add4    = pc4[31:0];
   assign bus64.in_pc_add4    = pc4;
   assign bus32.in_rs2        = rs2[31:0];
   assign bus64.in_rs2        = rs2;
   assign bus32.in_mem_op     = mem_op;
   assign bus64.in_mem_op     = mem_op;
   assign bus32.in_size       = size;
   assign bus64.in_size       = size;
   assign bus32.in_unsigned   = uns;
   assign bus64.in_unsigned   = uns;
   assign bus32.in_wb_sel     = wb_sel;
   assign bus64.in_wb_sel     = wb_sel;
   assign bus32.req_ready     = req_ready;
   assign bus64.req_ready     = req_ready;
   assign bus32.rsp_valid     = rsp_valid;
   assign bus64.rsp_valid     = rsp_valid;
   assign bus32.rsp_rdata     = rdata[31:0];
   assign bus64.rsp_rdata     = rdata;
   assign bus32.out_ready     = out_ready;
   assign bus64.out_ready     = out_ready;

   logic        m_in_ready, m_req_valid, m_req_we, m_out_valid, m_rf_we, m_mis;
   logic [63:0] m_req_addr, m_req_wdata, m_rf_wdata;
   logic [7:0]  m_wstrb;

   always_comb begin
      if (use64) begin
         m_in_ready  = bus64.in_ready;     m_req_valid = bus64.req_valid;
         m_req_we    = bus64.req_we;       m_out_valid = bus64.out_valid;
         m_rf_we     = bus64.out_rf_we;    m_mis       = bus64.out_misalign;
         m_req_addr  = bus64.req_addr;     m_req_wdata = bus64.req_wdata;
         m_rf_wdata  = bus64.out_rf_wdata; m_wstrb     = bus64.req_wstrb;
      end else begin
         m_in_ready  = bus32.in_ready;     m_req_valid = bus32.req_valid;
         m_req_we    = bus32.req_we;       m_out_valid = bus32.out_valid;
         m_rf_we     = bus32.out_rf_we;    m_mis       = bus32.out_misalign;
         m_req_addr  = {32'b0, bus32.req_addr};
         m_req_wdata = {32'b0, bus32.req_wdata};
         m_rf_wdata  = {32'b0, bus32.out_rf_wdata};
         m_wstrb     = {4'b0, bus32.req_wstrb};
      end
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      bit          need_req;
      logic [63:0] addr;
      bit          we;
      logic [63:0] wdata;
      logic [63:0] bmask;
      logic [7:0]  strb;
      bit          mis;
      bit          rf_we;
      bit          chk_wb;
      logic [63:0] wb;
   } exp_t;

   function automatic exp_t model(input bit w64, input logic [1:0] op, input logic [1:0] sz,
                                  input bit u, input bit sel, input logic [63:0] a_in,
                                  input logic [63:0] pc_in, input logic [63:0] d_in,
                                  input logic [63:0] rd_in);
      exp_t            e;
      longint unsigned wmask = w64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
      longint unsigned a     = a_in & wmask;
      int              nb    = w64 ? 8 : 4;
      int              bytes = 1 << sz;
      int              off   = int'(a % nb);
      bit              mem   = (op == 2'd1) || (op == 2'd2);
      longint unsigned v;
      e.mis      = mem && ((sz == 2'd3 && !w64) || (a % bytes != 0));
      e.need_req = mem && !e.mis;
      e.addr     = a - off;
      e.we       = op == 2'd2;
      e.strb     = e.we ? 8'(((1 << bytes) - 1) << off) : 8'h00;
      e.bmask    = '0;
      for (int i = 0; i < 8; i++) if (e.strb[i]) e.bmask |= 64'hFF << (8 * i);
      e.wdata    = ((d_in << (8 * off)) & wmask) & e.bmask;
      e.rf_we    = 1'b0;
      e.chk_wb   = 1'b1;
      e.wb       = '0;
      if (!mem) begin
         e.rf_we = 1'b1;
         e.wb    = (sel ? a : pc_in) & wmask;
      end else if (e.mis) begin
         e.wb = '0;
      end else if (e.we) begin
         e.chk_wb = 1'b0;
      end else begin
         v = (rd_in & wmask) >> (8 * off);
         if (bytes < 8) begin
            v = v % (64'd1 << (8 * bytes));
            if (!u && v >= (64'd1 << (8 * bytes - 1))) v = v - (64'd1 << (8 * bytes));
         end
         e.wb    = v & wmask;
         e.rf_we = 1'b1;
      end
      return e;
   endfunction

   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
   endtask

   task automatic run_txn(input string nm, input bit w64, input logic [1:0] op,
                          input logic [1:0] sz, input bit u, input bit sel,
                          input logic [63:0] a, input logic [63:0] pc, input logic [63:0] d,
                          input logic [63:0] rd, input int rq, input int rs, input int hold);
      exp_t e;
      int   cyc, exp_lat;
      bit   req_seen, responded, held_ok;
      e = model(w64, op, sz, u, sel, a, pc, d, rd);
      exp_lat = e.need_req ? 3 + rq + rs : 1;
      use64 = w64; in_valid = 1'b1; mem_op = op; size = sz; uns = u; wb_sel = sel;
      alu = a; pc4 = pc; rs2 = d; rdata = {$urandom, $urandom};
      req_ready = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0;
      #1;
      check({nm, ":in_ready_idle"}, m_in_ready, 1);
      step();
      // Scramble inputs after accept: the unit must work from its captured copy.
      in_valid = 1'b0; alu = {$urandom, $urandom}; rs2 = {$urandom, $urandom};
      pc4 = {$urandom, $urandom}; mem_op = 2'($urandom); size = 2'($urandom);
      uns = 1'($urandom); wb_sel = 1'($urandom);
      check({nm, ":in_ready_busy"}, m_in_ready, 0);
      cyc = 1; req_seen = 1'b0; responded = 1'b0;
      while (!m_out_valid && cyc < 40) begin
         req_ready = 1'b0; rsp_valid = 1'b0; rdata = {$urandom, $urandom};
         if (m_req_valid) begin
            if (!req_seen) begin
               check({nm, ":req_addr"}, m_req_addr, e.addr);
               check({nm, ":req_we"}, m_req_we, e.we);
               check({nm, ":req_wstrb"}, m_wstrb, e.strb);
               if (e.we) check({nm, ":req_wdata"}, m_req_wdata & e.bmask, e.wdata);
            end
            req_seen = 1'b1;
            if (rq == 0) req_ready = 1'b1;
            else begin
               rq--;
               rsp_valid = 1'($urandom);
            end
         end else if (req_seen && !responded) begin
            if (rs == 0) begin
               rsp_valid = 1'b1; rdata = rd; responded = 1'b1;
            end else rs--;
         end
         step();
         cyc++;
      end
      req_ready = 1'b0; rsp_valid = 1'b0;
      check({nm, ":latency"}, cyc, exp_lat);
      check({nm, ":req_issued"}, req_seen, e.need_req);
      if (!m_out_valid) begin
         pulse_reset();
         return;
      end
      held_ok = 1'b1;
      for (int i = 0; i < hold; i++) begin
         rsp_valid = 1'($urandom); req_ready = 1'($urandom); rdata = {$urandom, $urandom};
         step();
         if (!m_out_valid || m_in_ready) held_ok = 1'b0;
      end
      rsp_valid = 1'b0; req_ready = 1'b0;
      check({nm, ":held"}, held_ok, 1);
      check({nm, ":rf_we"}, m_rf_we, e.rf_we);
      check({nm, ":misalign"}, m_mis, e.mis);
      if (e.chk_wb) check({nm, ":rf_wdata"}, m_rf_wdata, e.wb);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check({nm, ":out_valid_drop"}, m_out_valid, 0);
      check({nm, ":in_ready_back"}, m_in_ready, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          w, u, sel, quiet;
      logic [1:0]  op, sz;
      logic [63:0] a;
      rst = 1'b1; use64 = 1'b0; in_valid = 1'b0; uns = 1'b0; wb_sel = 1'b0;
      req_ready = 1'b0; rsp_valid = 1'b0; out_ready = 1'b0; mem_op = 2'b00; size = 2'b00;
      alu = '0; pc4 = '0; rs2 = '0; rdata = '0;
      #1;
      check("rst32_in_ready", bus32.in_ready, 1);
      check("rst32_req_valid", bus32.req_valid, 0);
      check("rst32_out_valid", bus32.out_valid, 0);
      check("rst32_req_wstrb", bus32.req_wstrb, 0);
      check("rst64_req_we", bus64.req_we, 0);
      check("rst64_rf_we", bus64.out_rf_we, 0);
      check("rst64_misalign", bus64.out_misalign, 0);
      check("rst64_rf_wdata", bus64.out_rf_wdata, 0);
      check("rst64_req_addr", bus64.req_addr, 0);
      step();
      step();
      rst = 1'b0;
      step();

      run_txn("st_byte", 0, 2'd2, 2'd0, 0, 0, 64'h1003, 64'h0, 64'hA5, 64'h0, 0, 0, 0);
      run_txn("ld_half_s", 0, 2'd1, 2'd1, 0, 0, 64'h2002, 64'h0, 64'h0, 64'h8001_1234, 1, 0, 1);
      run_txn("ld_half_u", 0, 2'd1, 2'd1, 1, 0, 64'h2002, 64'h0, 64'h0, 64'h8001_1234, 0, 2, 0);
      run_txn("ld_word_mis", 0, 2'd1, 2'd2, 0, 0, 64'h3001, 64'h0, 64'h0, 64'h0, 0, 0, 0);
      run_txn("ld_dw_w32", 0, 2'd1, 2'd3, 0, 0, 64'h3000, 64'h0, 64'h0, 64'h0, 0, 0, 0);
      run_txn("nonmem_pc4", 0, 2'd0, 2'd0, 0, 0, 64'h1234, 64'h8000_0004, 64'h0, 64'h0,
              0, 0, 3);
      run_txn("op11_alu", 1, 2'd3, 2'd2, 0, 1, 64'hDEAD_BEEF_0000_0007, 64'h4, 64'h0, 64'h0,
              0, 0, 0);
      run_txn("ld_dw_w64", 1, 2'd1, 2'd3, 0, 0, 64'h10, 64'h0, 64'h0,
              64'hF123_4567_89AB_CDEF, 2, 3, 0);
      run_txn("st_half_w64", 1, 2'd2, 2'd1, 0, 0, 64'h0000_0000_0000_4006, 64'h0,
              64'h1111_2222_3333_BEEF, 64'h0, 1, 1, 2);
      run_txn("ld_word_w64", 1, 2'd1, 2'd2, 0, 0, 64'h104, 64'h0, 64'h0,
              64'h9ABC_DEF0_1234_5678, 0, 0, 0);

      // Reset while a request is stalled; a late response must not resurrect it.
      use64 = 1'b1; in_valid = 1'b1; mem_op = 2'd1; size = 2'd3; alu = 64'h20;
      step();
      in_valid = 1'b0;
      step();
      step();
      check("rstmid_req_valid_before", m_req_valid, 1);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_req_valid", m_req_valid, 0);
      check("rstmid_in_ready", m_in_ready, 1);
      #1;
      rst = 1'b0;
      step();
      rsp_valid = 1'b1;
      quiet = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         rsp_valid = 1'b0;
         if (m_out_valid || !m_in_ready) quiet = 1'b0;
      end
      check("rstmid_quiet", quiet, 1);

      for (int k = 0; k < 150; k++) begin
         w   = 1'($urandom);
         op  = 2'($urandom);
         sz  = 2'($urandom);
         u   = 1'($urandom);
         sel = 1'($urandom);
         a   = {$urandom, $urandom};
         if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         run_txn("rand", w, op, sz, u, sel, a, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
